// File: rtl/bus_mailbox_pkg.sv
// ============================================================================
// Module  : bus_mailbox_pkg
// Brief   : Register offsets, STATUS bit positions and THRESH width for bus_mailbox.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package bus_mailbox_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_THRESH = 2'd2,
        REG_RSVD   = 2'd3
    } reg_off_e;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_UNF     = 5;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;
    localparam int ST_CNT_W      = 8;

    localparam int THRESH_W = 8;

endpackage

`default_nettype wire

// File: rtl/bus_mailbox_fifo.sv
// ============================================================================
// Module  : mailbox_fifo
// Brief   : Synchronous show-ahead FIFO; push ignored when full, pop ignored when empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mailbox_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int CntW = $clog2(Depth+1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Head is masked while empty so the stream output idles at zero.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_mailbox.sv
// ============================================================================
// Module  : bus_mailbox
// Brief   : Ibex-bus device with TX/RX mailbox FIFOs, STATUS/THRESH registers and irq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bus_mailbox
    import bus_mailbox_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int Depth        = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [AddressWidth-1:0]   addr_i,
    input  logic                      we_i,
    input  logic [DataWidth/8-1:0]    be_i,
    input  logic [DataWidth-1:0]      wdata_i,
    output logic                      rvalid_o,
    output logic [DataWidth-1:0]      rdata_o,
    output logic                      err_o,
    output logic                      tx_valid_o,
    output logic [DataWidth-1:0]      tx_data_o,
    input  logic                      tx_ready_i,
    input  logic                      rx_valid_i,
    input  logic [DataWidth-1:0]      rx_data_i,
    output logic                      rx_ready_o,
    output logic                      irq_o
);

    localparam int CntW = $clog2(Depth+1);

    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  ovf_q, unf_q;
    logic [THRESH_W-1:0]   thresh_q, thresh_d;
    logic                  irq_q;

    logic                  tx_push, tx_full, tx_empty;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [CntW-1:0]       tx_count, rx_count;
    logic [DataWidth-1:0]  rx_head;
    logic                  ovf_set, ovf_clr, unf_set, unf_clr;
    logic [DataWidth-1:0]  status_word;
    reg_off_e              reg_off;
    logic                  unused_addr;

    assign unused_addr = ^addr_i[AddressWidth-1:4];

    assign rx_ready_o = ~rx_full & ~rst_i;
    assign rx_push    = rx_valid_i & rx_ready_o;
    assign tx_valid_o = ~tx_empty;

    mailbox_fifo #(.Width(DataWidth), .Depth(Depth)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .wdata_i (wdata_i),
        .pop_i   (tx_ready_i),
        .rdata_o (tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    mailbox_fifo #(.Width(DataWidth), .Depth(Depth)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .wdata_i (rx_data_i),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        status_word                              = '0;
        status_word[ST_TX_EMPTY]                 = tx_empty;
        status_word[ST_TX_FULL]                  = tx_full;
        status_word[ST_RX_EMPTY]                 = rx_empty;
        status_word[ST_RX_FULL]                  = rx_full;
        status_word[ST_TX_OVF]                   = ovf_q;
        status_word[ST_RX_UNF]                   = unf_q;
        status_word[ST_TX_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(tx_count);
        status_word[ST_RX_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(rx_count);
    end

    // Full/empty decisions use start-of-cycle FIFO state, so a same-cycle
    // stream pop/push never rescues a bus access that would otherwise fail.
    always_comb begin
        rvalid_d = req_i;
        err_d    = 1'b0;
        rdata_d  = '0;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        ovf_set  = 1'b0;
        ovf_clr  = 1'b0;
        unf_set  = 1'b0;
        unf_clr  = 1'b0;
        thresh_d = thresh_q;
        reg_off  = reg_off_e'(addr_i[3:2]);
        if (req_i) begin
            if (addr_i[1:0] != 2'b00) begin
                err_d = 1'b1;
            end else begin
                case (reg_off)
                    REG_DATA: begin
                        if (we_i) begin
                            if (be_i != '1) begin
                                err_d = 1'b1;
                            end else if (tx_full) begin
                                err_d   = 1'b1;
                                ovf_set = 1'b1;
                            end else begin
                                tx_push = 1'b1;
                            end
                        end else if (rx_empty) begin
                            err_d   = 1'b1;
                            unf_set = 1'b1;
                        end else begin
                            rx_pop  = 1'b1;
                            rdata_d = rx_head;
                        end
                    end
                    REG_STATUS: begin
                        if (we_i) begin
                            if (be_i[0]) begin
                                ovf_clr = wdata_i[ST_TX_OVF];
                                unf_clr = wdata_i[ST_RX_UNF];
                            end
                        end else begin
                            rdata_d = status_word;
                        end
                    end
                    REG_THRESH: begin
                        if (we_i) begin
                            if (be_i[0]) begin
                                thresh_d = wdata_i[THRESH_W-1:0];
                            end
                        end else begin
                            rdata_d = {{(DataWidth-THRESH_W){1'b0}}, thresh_q};
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_set | (ovf_q & ~ovf_clr);
            unf_q    <= unf_set | (unf_q & ~unf_clr);
            thresh_q <= thresh_d;
            irq_q    <= (thresh_q != '0) && (THRESH_W'(rx_count) >= thresh_q);
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;

endmodule

`default_nettype wire
